// File: rtl/char_buffer_writer.sv
// Writer side of the VGA text line buffer: printable bytes, backspace, form-feed clear.
// Optional feature macro VBLANK_SYNC_EN: char is a shadow copy refreshed at the start of each vsync pulse.
module char_buffer_writer #(
    parameter int unsigned  NUM_CHARS  = 41,
    parameter logic [7:0]   BLANK_CODE = 8'd0,
    localparam int unsigned CW         = $clog2(NUM_CHARS + 1)
) (
    input  logic          clock_25,
    input  logic          reset,
    input  logic [7:0]    in_char,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          vsync,
    output logic [7:0]    char [NUM_CHARS],
    output logic [CW-1:0] cursor,
    output logic          overflow
);

    localparam logic [7:0]    CODE_BS  = 8'h08;
    localparam logic [7:0]    CODE_FF  = 8'h0C;
    localparam logic [7:0]    PRINT_LO = 8'h20;
    localparam logic [7:0]    PRINT_HI = 8'h7E;
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] FULL     = CW'(NUM_CHARS);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CHARS - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t        r_state;
    logic          r_ready;
    logic [CW-1:0] r_cursor;
    logic [CW-1:0] r_clr_idx;
    logic          r_overflow;
    logic [7:0]    r_cells [NUM_CHARS];

    logic w_accept;
    logic w_printable;
    logic w_room;

    assign w_accept    = in_valid & r_ready;
    assign w_printable = (in_char >= PRINT_LO) && (in_char <= PRINT_HI);
    assign w_room      = r_cursor < FULL;

    // Edit FSM: IDLE decodes bytes, CLEAR blanks one cell per cycle with the input stalled.
    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b1;
            r_cursor   <= '0;
            r_clr_idx  <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < NUM_CHARS; i++) begin
                r_cells[i] <= BLANK_CODE;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_printable) begin
                            if (w_room) begin
                                r_cells[r_cursor] <= in_char;
                                r_cursor          <= r_cursor + ONE;
                            end else begin
                                r_overflow <= 1'b1;
                            end
                        end else if (in_char == CODE_BS) begin
                            if (r_cursor != '0) begin
                                r_cells[r_cursor - ONE] <= BLANK_CODE;
                                r_cursor                <= r_cursor - ONE;
                            end
                        end else if (in_char == CODE_FF) begin
                            r_state   <= S_CLEAR;
                            r_ready   <= 1'b0;
                            r_clr_idx <= '0;
                        end
                    end
                end
                S_CLEAR: begin
                    r_cells[r_clr_idx] <= BLANK_CODE;
                    if (r_clr_idx == LAST_IDX) begin
                        r_state    <= S_IDLE;
                        r_ready    <= 1'b1;
                        r_cursor   <= '0;
                        r_overflow <= 1'b0;
                        r_clr_idx  <= '0;
                    end else begin
                        r_clr_idx <= r_clr_idx + ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready = r_ready;
    assign cursor   = r_cursor;
    assign overflow = r_overflow;

`ifdef VBLANK_SYNC_EN
    logic       r_vs_meta;
    logic       r_vs_sync;
    logic       r_vs_prev;
    logic [7:0] r_shadow [NUM_CHARS];
    logic       w_vs_fall;

    assign w_vs_fall = r_vs_prev & ~r_vs_sync;

    // Sync flops idle high so reset release never looks like a vsync falling edge.
    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            r_vs_meta <= 1'b1;
            r_vs_sync <= 1'b1;
            r_vs_prev <= 1'b1;
            for (int i = 0; i < NUM_CHARS; i++) begin
                r_shadow[i] <= BLANK_CODE;
            end
        end else begin
            r_vs_meta <= vsync;
            r_vs_sync <= r_vs_meta;
            r_vs_prev <= r_vs_sync;
            if (w_vs_fall) begin
                for (int i = 0; i < NUM_CHARS; i++) begin
                    r_shadow[i] <= r_cells[i];
                end
            end
        end
    end

    assign char = r_shadow;
`else
    logic w_unused_vsync;
    assign w_unused_vsync = vsync;
    assign char           = r_cells;
`endif

endmodule

// File: tb/tb_char_buffer_writer.sv
// Randomized self-checking bench for char_buffer_writer against a behavioural line model.
// Also covers the VBLANK_SYNC_EN build when that macro is defined.
module tb_char_buffer_writer;

    localparam int unsigned N  = 41;
    localparam int unsigned CW = 6;
    localparam int unsigned LW = N * 8;

    logic          clk;
    logic          rst;
    logic [7:0]    in_char;
    logic          in_valid;
    logic          in_ready;
    logic          vsync;
    logic [7:0]    t_char [N];
    logic [CW-1:0] cursor;
    logic          overflow;

    int n_checks;
    int n_errors;
    bit prev_ff;

    logic [7:0] m_cells  [N];
    logic [7:0] m_shadow [N];
    int         m_cur;
    bit         m_ovf;

    char_buffer_writer dut (
        .clock_25 (clk),
        .reset    (rst),
        .in_char  (in_char),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .vsync    (vsync),
        .char     (t_char),
        .cursor   (cursor),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check_val(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] dut_line();
        logic [LW-1:0] v;
        for (int i = 0; i < N; i++) v[i*8 +: 8] = t_char[i];
        return v;
    endfunction

    function automatic logic [LW-1:0] exp_line();
        logic [LW-1:0] v;
        for (int i = 0; i < N; i++) begin
`ifdef VBLANK_SYNC_EN
            v[i*8 +: 8] = m_shadow[i];
`else
            v[i*8 +: 8] = m_cells[i];
`endif
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cells[i]  = 8'h00;
            m_shadow[i] = 8'h00;
        end
        m_cur   = 0;
        m_ovf   = 1'b0;
        prev_ff = 1'b0;
    endtask

    // Line editor semantics: the form feed result is applied at once; its stall is checked separately.
    task automatic model_apply(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            if (m_cur < N) begin
                m_cells[m_cur] = b;
                m_cur++;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (b == 8'h08) begin
            if (m_cur > 0) begin
                m_cur--;
                m_cells[m_cur] = 8'h00;
            end
        end else if (b == 8'h0C) begin
            for (int i = 0; i < N; i++) m_cells[i] = 8'h00;
            m_cur = 0;
            m_ovf = 1'b0;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with in_valid dropped.
    task automatic send_byte(input logic [7:0] b, output int waited);
        in_char  = b;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 200) begin
            @(posedge clk);
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL ready_timeout: got in_ready=0 expected 1 within 200 cycles");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            model_apply(b);
        end
    endtask

    task automatic do_byte(input logic [7:0] b);
        int waited;
        send_byte(b, waited);
        check_val("stall_cycles", LW'(waited), LW'(prev_ff ? N : 0));
        if (b == 8'h0C) begin
            check_val("ready_low_ff", LW'(in_ready), LW'(0));
        end else begin
            check_val("ready", LW'(in_ready), LW'(1));
            check_val("cursor", LW'(cursor), LW'(m_cur));
            check_val("overflow", LW'(overflow), LW'(m_ovf));
            check_val("line", dut_line(), exp_line());
        end
        prev_ff = (b == 8'h0C);
    endtask

    task automatic frame_sync();
        vsync = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < N; i++) m_shadow[i] = m_cells[i];
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        check_val("frame_line", dut_line(), exp_line());
    endtask

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        int         r;
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_char  = 8'h00;
        vsync    = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_cursor", LW'(cursor), LW'(0));
        check_val("rst_overflow", LW'(overflow), LW'(0));
        check_val("rst_ready", LW'(in_ready), LW'(1));
        check_val("rst_line", dut_line(), '0);

        do_byte(8'h41);
        do_byte(8'h42);
        repeat (3) do_byte(8'h08);

        repeat (N) do_byte(8'h58);
        do_byte(8'h59);
        do_byte(8'h08);
        do_byte(8'h0C);
        do_byte(8'h5A);

        // Reset in the middle of a clear sweep.
        do_byte(8'h43);
        do_byte(8'h0C);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("midclr_cursor", LW'(cursor), LW'(0));
        check_val("midclr_overflow", LW'(overflow), LW'(0));
        check_val("midclr_ready", LW'(in_ready), LW'(1));
        check_val("midclr_line", dut_line(), '0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_ready", LW'(in_ready), LW'(1));

`ifdef VBLANK_SYNC_EN
        do_byte(8'h41);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        check_val("vblank_char0", LW'(t_char[0]), LW'(8'h41));
        vsync = 1'b1;
        for (int i = 0; i < N; i++) m_shadow[i] = m_cells[i];
        repeat (3) @(negedge clk);
`endif

        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 62) begin
                b = 8'($urandom_range(32, 126));
            end else if (r < 80) begin
                b = 8'h08;
            end else if (r < 82) begin
                b = 8'h0C;
            end else begin
                do b = 8'($urandom_range(0, 255));
                while ((b >= 8'h20 && b <= 8'h7E) || b == 8'h08 || b == 8'h0C);
            end
`ifndef VBLANK_SYNC_EN
            vsync = 1'($urandom_range(0, 1));
`endif
            do_byte(b);
`ifdef VBLANK_SYNC_EN
            if (b != 8'h0C && $urandom_range(0, 3) == 0) frame_sync();
`endif
            if (b != 8'h0C) repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/char_buffer_writer.md
Name: char_buffer_writer

Overview:
Writer side of the 41-entry character buffer that the VGA text path reads and renders.
Accepts a stream of ASCII bytes over a valid/ready handshake and keeps the display-line array and its cursor.
Handles printable characters, backspace and form-feed clear.
Drives the `char` array consumed by the VGA controller; sits between the input source (keyboard/UART decoder) and the VGA controller.

Parameters:
- NUM_CHARS, 41, number of character cells; the output array is indexed 0..NUM_CHARS-1.
- BLANK_CODE, 8'd0, code written to an empty cell; the renderer draws nothing for it.
- CW, $clog2(NUM_CHARS+1), cursor width; 6 for the default.

Ports:
- clock_25  input  1  pixel clock, rising-edge; the only clock.
- reset  input  1  asynchronous, active-high reset.
- in_char  input  8  ASCII byte from the source.
- in_valid  input  1  in_char is valid this cycle.
- in_ready  output  1  block can accept a byte this cycle.
- vsync  input  1  VGA vertical sync, active low; used only with VBLANK_SYNC_EN.
- char  output  [0:7] x [0:NUM_CHARS-1]  character array to the VGA controller.
- cursor  output  CW  index of the next cell to write; NUM_CHARS means the line is full.
- overflow  output  1  sticky flag: a printable byte was dropped because the line was full.

Behaviour:
- One clock and one reset, as fixed above: clock_25, asynchronous active-high reset.
- Reset values:
  - every char cell = BLANK_CODE; working array and shadow array both cleared.
  - cursor = 0, overflow = 0, in_ready = 1, state = IDLE.
- Accept: a byte is accepted on a clock_25 rising edge when in_valid && in_ready.
- Latency: the effect of an accepted byte is visible on char/cursor/overflow right after that same edge (registered, 1-cycle).
- State machine: IDLE and CLEAR.
  - IDLE: in_ready = 1. Decode of an accepted byte:
    - 0x20..0x7E, cursor < NUM_CHARS: cell[cursor] <= in_char; cursor <= cursor+1.
    - 0x20..0x7E, cursor == NUM_CHARS: byte dropped; overflow <= 1; cursor unchanged.
    - 0x08 (backspace), cursor > 0: cursor <= cursor-1; cell[cursor-1] <= BLANK_CODE; overflow unchanged.
    - 0x08, cursor == 0: no effect.
    - 0x0C (form feed): go to CLEAR; clear index k <= 0.
    - Any other code: accepted and discarded, no state change.
  - CLEAR: in_ready = 0.
    - Each cycle: cell[k] <= BLANK_CODE, k <= k+1.
    - After the cycle that writes cell[NUM_CHARS-1]: cursor <= 0, overflow <= 0, return to IDLE.
    - Total time in_ready is low: exactly NUM_CHARS cycles (41).
  - in_valid held during CLEAR is not consumed; it is accepted on the first IDLE cycle.
- Reset asserted mid-CLEAR or mid-stream: immediate return to reset values; no partial state survives.
- Cursor arithmetic saturates: never above NUM_CHARS, never below 0.
- Cells not addressed in a cycle hold their value.

Optional Feature:
- Macro: VBLANK_SYNC_EN.
- Defined:
  - Edits go to a working array; char is driven from a separate shadow array.
  - vsync is registered through two flops. On a detected falling edge (start of the vertical sync pulse), the whole working array is copied into the shadow array in one cycle.
  - cursor and overflow always reflect the working state immediately.
  - Reset clears both arrays.
  - Result: no tearing mid-frame.
- Not defined: char is driven directly from the working array; vsync is ignored; the 2-flop vsync synchronizer and edge detector are not built.

Test Plan:
- Reset, then send 0x41, 0x42 -> char[0]=0x41, char[1]=0x42, char[2..40]=0x00, cursor=2, in_ready=1 throughout.
- From cursor=2, send 0x08 twice, then a third 0x08 -> after two: cursor=0, char[0]=char[1]=0x00; third: no change.
- Send 41 x 0x58, then 0x59 -> cursor=41, all cells 0x58, overflow=1, 0x59 absent; then 0x08 -> cursor=40, char[40]=0x00, overflow still 1.
- Full line, send 0x0C with in_valid held on 0x5A -> in_ready low for exactly 41 cycles, all cells 0x00, cursor=0, overflow=0; 0x5A lands in char[0] on the first ready cycle.
- Assert reset 10 cycles into CLEAR -> all outputs at reset values immediately; in_ready=1 after reset release.
- With VBLANK_SYNC_EN, send 0x41 with vsync high -> char[0] stays 0x00 until vsync falls; char[0]=0x41 within 3 cycles of the falling edge; cursor=1 immediately after accept.
